eeprom_ram_bridge: RTL

Backing-store bridge for the 24C0x serial EEPROM model. It services the EEPROM's level-held `ram_read`/`ram_write` requests against a shared byte-wide save memory, and arbitrates a host save-file port (load/upload of the `.sav` image) onto the same memory. It also tracks a dirty flag, so the host knows when the EEPROM contents have changed since the last save.

---
 rtl/eeprom_ram_bridge.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/eeprom_ram_bridge.sv
// eeprom_ram_bridge: services the serial EEPROM model's level-held read/write
// requests against a shared byte-wide save memory, arbitrates a host save-file
// port onto the same memory, and keeps a dirty flag for EEPROM writes.
module eeprom_ram_bridge #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  // EEPROM side
  input  logic              type_24C01,
  input  logic [7:0]        ram_addr,
  input  logic              ram_read,
  input  logic              ram_write,
  input  logic [7:0]        data_to_ram,
  output logic [7:0]        data_from_ram,
  output logic              ram_done,
  // backing memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  // host save-file side
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_rd,
  input  logic              host_wr,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  // dirty tracking
  output logic              dirty,
  input  logic              dirty_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EE_MEM,
    S_EE_DONE,
    S_HOST_MEM
  } state_t;

  state_t              r_state;

  // memory strobe / address registers (stable for the whole strobe)
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic                r_mem_rd;
  logic                r_mem_wr;

  // EEPROM / host result registers
  logic [7:0]          r_data_from_ram;
  logic                r_ram_done;
  logic [7:0]          r_host_rdata;
  logic                r_host_ack;
  logic                r_dirty;

  // pending host request slot
  logic                r_host_pend;
  logic [ADDR_W-1:0]   r_host_addr;
  logic [7:0]          r_host_wdata;
  logic                r_host_is_wr;

  logic                w_ee_req;
  logic [ADDR_W-1:0]   w_ee_addr;
  logic                w_host_take;
  logic                w_host_done;
  logic                w_dirty_set;

  assign w_ee_req    = ram_read | ram_write;
  // host_ready is simply "slot empty", so a strobe is taken only when free
  assign w_host_take = (host_rd | host_wr) & ~r_host_pend;
  assign w_host_done = (r_state == S_HOST_MEM) & mem_ack;
  // r_mem_wr is still high in the ack cycle, so it marks an EEPROM write
  assign w_dirty_set = (r_state == S_EE_MEM) & mem_ack & r_mem_wr;

  // EEPROM address zero-extended; the 128-byte part ignores address bit 7
  always_comb begin
    w_ee_addr      = '0;
    w_ee_addr[7:0] = ram_addr;
    if (type_24C01) begin
      w_ee_addr[7] = 1'b0;
    end
  end

  // Host latch: capture one request into the slot, free it when serviced
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_host_pend  <= 1'b0;
      r_host_addr  <= '0;
      r_host_wdata <= '0;
      r_host_is_wr <= 1'b0;
    end else if (w_host_take) begin
      r_host_pend  <= 1'b1;
      r_host_addr  <= host_addr;
      r_host_wdata <= host_wdata;
      r_host_is_wr <= host_wr;   // simultaneous rd+wr: write wins
    end else if (w_host_done) begin
      r_host_pend  <= 1'b0;
    end
  end

  // Arbitration FSM: EEPROM first, then the pending host request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_rd        <= 1'b0;
      r_mem_wr        <= 1'b0;
      r_data_from_ram <= '0;
      r_ram_done      <= 1'b0;
      r_host_rdata    <= '0;
      r_host_ack      <= 1'b0;
    end else begin
      r_host_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ee_req) begin
            r_state     <= S_EE_MEM;
            r_mem_addr  <= w_ee_addr;
            r_mem_wdata <= data_to_ram;
            r_mem_wr    <= ram_write;
            r_mem_rd    <= ~ram_write;
          end else if (r_host_pend) begin
            r_state     <= S_HOST_MEM;
            r_mem_addr  <= r_host_addr;
            r_mem_wdata <= r_host_wdata;
            r_mem_wr    <= r_host_is_wr;
            r_mem_rd    <= ~r_host_is_wr;
          end
        end
        S_EE_MEM: begin
          if (mem_ack) begin
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            if (r_mem_rd) begin
              r_data_from_ram <= mem_rdata;
            end
            r_ram_done <= 1'b1;
            r_state    <= S_EE_DONE;
          end
        end
        S_EE_DONE: begin
          // 4-phase handshake: wait for the EEPROM to release its request
          if (!w_ee_req) begin
            r_ram_done <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_HOST_MEM: begin
          if (mem_ack) begin
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_host_ack <= 1'b1;
            if (r_mem_rd) begin
              r_host_rdata <= mem_rdata;
            end
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Dirty flag: set by completed EEPROM writes, set beats clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dirty <= 1'b0;
    end else if (w_dirty_set) begin
      r_dirty <= 1'b1;
    end else if (dirty_clr) begin
      r_dirty <= 1'b0;
    end
  end

  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_rd        = r_mem_rd;
  assign mem_wr        = r_mem_wr;
  assign data_from_ram = r_data_from_ram;
  assign ram_done      = r_ram_done;
  assign host_rdata    = r_host_rdata;
  assign host_ack      = r_host_ack;
  assign host_ready    = ~r_host_pend;
  assign dirty         = r_dirty;

endmodule
